// File: rtl/mpmc12_pkg.sv
// mpmc12_pkg: shared types and default constants for the mpmc12 controller.
//   mpmc12_state_t   controller FSM state encoding
//   MPMC12_CW        default burst counter width
//   MPMC12_MAX_OUT   default read-credit window (beats in flight)
package mpmc12_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    PRESET1     = 4'd1,
    PRESET2     = 4'd2,
    PRESET3     = 4'd3,
    WRITE_DATA0 = 4'd4,
    WRITE_DATA1 = 4'd5,
    WRITE_DATA2 = 4'd6,
    READ_DATA0  = 4'd7,
    READ_DATA1  = 4'd8,
    READ_DATA2  = 4'd9,
    DONE        = 4'd10
  } mpmc12_state_t;

  localparam int unsigned MPMC12_CW      = 8;
  localparam int unsigned MPMC12_MAX_OUT = 8;

endpackage

// File: rtl/mpmc12_beat_ctr.sv
// mpmc12_beat_ctr: CW-bit beat counter with arm/disarm, limit and sticky done.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       synchronous clear to reset values (highest priority)
//   i_start     clear count and done, arm the counter
//   i_disarm    stop counting without setting done
//   i_inc       one beat this cycle (ignored while disarmed)
//   i_lim       last beat index (beats minus one)
//   o_cnt       beats counted so far, saturating at i_lim
//   o_on        counter armed
//   o_hit       armed and o_cnt == i_lim
//   o_done      sticky: i_lim+1 beats counted
module mpmc12_beat_ctr #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_start,
  input  logic          i_disarm,
  input  logic          i_inc,
  input  logic [CW-1:0] i_lim,
  output logic [CW-1:0] o_cnt,
  output logic          o_on,
  output logic          o_hit,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;
  logic          r_on;
  logic          r_done;
  logic          w_hit;

  assign w_hit = r_on && (r_cnt == i_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_on   <= 1'b0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_on   <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_on   <= 1'b1;
      r_done <= 1'b0;
    end else if (i_disarm) begin
      r_on   <= 1'b0;
    end else if (i_inc && r_on) begin
      // The final beat leaves the count at the limit and disarms.
      if (w_hit) begin
        r_on   <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_on   = r_on;
  assign o_hit  = w_hit;
  assign o_done = r_done;

endmodule

// File: rtl/mpmc12_burst_ctr.sv
// mpmc12_burst_ctr: per-request burst sequencer between the mpmc12 FSM and
// the MIG-style app interface. Counts issued command beats and returned read
// beats, and limits in-flight read beats to a credit window.
//   clk, rst_n     clock, asynchronous active-low reset
//   state          controller FSM state
//   wdf_rdy        write-data FIFO ready
//   rdy            command accepted by the memory interface
//   rd_data_valid  one read beat returned this cycle
//   burst_len      beats minus one, captured in PRESET3
//   cmd_en         this cycle may issue a command beat (combinational)
//   burst_cnt      command beats issued
//   dat_cnt        read beats returned
//   outstanding    read beats in flight
//   cmd_last       command side armed and on its last beat
//   cmd_done       sticky: all command beats issued
//   dat_done       sticky: all read beats returned
module mpmc12_burst_ctr
  import mpmc12_pkg::*;
#(
  parameter int unsigned CW      = MPMC12_CW,
  parameter int unsigned MAX_OUT = MPMC12_MAX_OUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  mpmc12_state_t state,
  input  logic          wdf_rdy,
  input  logic          rdy,
  input  logic          rd_data_valid,
  input  logic [CW-1:0] burst_len,
  output logic          cmd_en,
  output logic [CW-1:0] burst_cnt,
  output logic [CW-1:0] dat_cnt,
  output logic [CW:0]   outstanding,
  output logic          cmd_last,
  output logic          cmd_done,
  output logic          dat_done
);

  localparam logic [CW:0] LP_MAX_OUT = (CW+1)'(MAX_OUT);

  logic [CW-1:0] r_len_q;
  logic [CW:0]   r_outstanding;
  logic          w_idle;
  logic          w_preset;
  logic          w_wr_state;
  logic          w_rd_issue_state;
  logic          w_rd_state;
  logic          w_cmd_on;
  logic          w_dat_on;
  logic          w_cmd_hit;
  logic          w_dat_hit;
  logic          w_cmd_en;
  logic          w_issue;
  logic          w_rd_issue;
  logic          w_dat_beat;

  assign w_idle           = (state == IDLE);
  assign w_preset         = (state == PRESET3);
  assign w_wr_state       = (state == WRITE_DATA1);
  assign w_rd_issue_state = (state == READ_DATA0) || (state == READ_DATA2);
  assign w_rd_state       = w_rd_issue_state || (state == READ_DATA1);

  // Writes are not credit-limited; only read issues consume the window.
  assign w_cmd_en = w_cmd_on && ((r_outstanding < LP_MAX_OUT) || w_wr_state);

  always_comb begin
    w_issue = 1'b0;
    if (w_wr_state)
      w_issue = w_cmd_en && wdf_rdy && rdy;
    else if (w_rd_issue_state)
      w_issue = w_cmd_en && rdy;
  end

  assign w_rd_issue = w_issue && w_rd_issue_state;
  assign w_dat_beat = rd_data_valid && w_dat_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_len_q <= '0;
    else if (w_idle)
      r_len_q <= '0;
    else if (w_preset)
      r_len_q <= burst_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else if (w_idle || w_preset) begin
      r_outstanding <= '0;
    end else if (w_rd_state) begin
      // Simultaneous issue and return cancel; a return with nothing in
      // flight is dropped so the window never underflows.
      if (w_rd_issue && !w_dat_beat)
        r_outstanding <= r_outstanding + (CW+1)'(1);
      else if (!w_rd_issue && w_dat_beat && (r_outstanding != '0))
        r_outstanding <= r_outstanding - (CW+1)'(1);
    end
  end

  mpmc12_beat_ctr #(.CW(CW)) u_cmd_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_idle),
    .i_start  (w_preset),
    .i_disarm (1'b0),
    .i_inc    (w_issue),
    .i_lim    (r_len_q),
    .o_cnt    (burst_cnt),
    .o_on     (w_cmd_on),
    .o_hit    (w_cmd_hit),
    .o_done   (cmd_done)
  );

  // A write burst never returns read data, so the data side is disarmed
  // as soon as the write phase begins.
  mpmc12_beat_ctr #(.CW(CW)) u_dat_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_idle),
    .i_start  (w_preset),
    .i_disarm (w_wr_state),
    .i_inc    (w_dat_beat),
    .i_lim    (r_len_q),
    .o_cnt    (dat_cnt),
    .o_on     (w_dat_on),
    .o_hit    (w_dat_hit),
    .o_done   (dat_done)
  );

  assign cmd_en      = w_cmd_en;
  assign cmd_last    = w_cmd_hit;
  assign outstanding = r_outstanding;

endmodule

// File: tb/tb_mpmc12_burst_ctr.sv
module tb_mpmc12_burst_ctr;
  import mpmc12_pkg::*;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  mpmc12_state_t state;
  logic          wdf_rdy;
  logic          rdy;
  logic          rd_data_valid;
  logic [CW-1:0] burst_len;
  logic          cmd_en;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] dat_cnt;
  logic [CW:0]   outstanding;
  logic          cmd_last;
  logic          cmd_done;
  logic          dat_done;

  int nvec;
  int nerr;

  mpmc12_burst_ctr #(.CW(CW), .MAX_OUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .state         (state),
    .wdf_rdy       (wdf_rdy),
    .rdy           (rdy),
    .rd_data_valid (rd_data_valid),
    .burst_len     (burst_len),
    .cmd_en        (cmd_en),
    .burst_cnt     (burst_cnt),
    .dat_cnt       (dat_cnt),
    .outstanding   (outstanding),
    .cmd_last      (cmd_last),
    .cmd_done      (cmd_done),
    .dat_done      (dat_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [CW-1:0] len);
    wdf_rdy = 1'b0; rdy = 1'b0; rd_data_valid = 1'b0;
    state = IDLE;
    tick();
    state = PRESET3;
    burst_len = len;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; state = IDLE; wdf_rdy = 1'b0; rdy = 1'b0;
    rd_data_valid = 1'b0; burst_len = '0;
    #2;
    nvec++;
    if ({cmd_en, burst_cnt, dat_cnt, outstanding, cmd_last, cmd_done, dat_done} !== '0) begin
      nerr++;
      $display("FAIL reset outputs: got en=%b bc=%0d dc=%0d out=%0d last=%b cd=%b dd=%b, want all 0",
               cmd_en, burst_cnt, dat_cnt, outstanding, cmd_last, cmd_done, dat_done);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_len3();
    preset(8'd3);
    state = WRITE_DATA1; wdf_rdy = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++;
      if (burst_cnt !== CW'(k) || cmd_last !== (k == 3) || cmd_en !== 1'b1) begin
        nerr++;
        $display("FAIL wr3 beat%0d: got cnt=%0d last=%b en=%b, want cnt=%0d last=%b en=1",
                 k, burst_cnt, cmd_last, cmd_en, k, (k == 3));
      end
      tick();
    end
    #1;
    nvec++;
    if (cmd_done !== 1'b1 || burst_cnt !== 8'd3 || dat_done !== 1'b0 || cmd_en !== 1'b0 || cmd_last !== 1'b0) begin
      nerr++;
      $display("FAIL wr3 done: got cd=%b cnt=%0d dd=%b en=%b last=%b, want cd=1 cnt=3 dd=0 en=0 last=0",
               cmd_done, burst_cnt, dat_done, cmd_en, cmd_last);
    end
    tick();
    tick();
    nvec++;
    if (burst_cnt !== 8'd3 || dat_done !== 1'b0 || cmd_done !== 1'b1) begin
      nerr++;
      $display("FAIL wr3 hold: got cnt=%0d dd=%b cd=%b, want cnt=3 dd=0 cd=1", burst_cnt, dat_done, cmd_done);
    end
  endtask

  task automatic test_write_toggle();
    int exp;
    preset(8'd3);
    state = WRITE_DATA1; rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdf_rdy = ((i % 2) == 0);
      exp = (i + 1) / 2;
      if (exp > 3) exp = 3;
      #1;
      nvec++;
      if (burst_cnt !== CW'(exp)) begin
        nerr++;
        $display("FAIL wrtoggle cyc%0d: got cnt=%0d, want %0d", i, burst_cnt, exp);
      end
      tick();
    end
    #1;
    nvec++;
    if (cmd_done !== 1'b1 || burst_cnt !== 8'd3) begin
      nerr++;
      $display("FAIL wrtoggle done: got cd=%b cnt=%0d, want cd=1 cnt=3", cmd_done, burst_cnt);
    end
  endtask

  task automatic test_read_credit();
    preset(8'd15);
    state = READ_DATA0; rdy = 1'b1; rd_data_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++;
      if (cmd_en !== 1'b1 || outstanding !== 9'(k)) begin
        nerr++;
        $display("FAIL credit issue%0d: got en=%b out=%0d, want en=1 out=%0d", k, cmd_en, outstanding, k);
      end
      tick();
    end
    #1;
    nvec++;
    if (cmd_en !== 1'b0 || outstanding !== 9'd4 || burst_cnt !== 8'd4) begin
      nerr++;
      $display("FAIL credit full: got en=%b out=%0d cnt=%0d, want en=0 out=4 cnt=4", cmd_en, outstanding, burst_cnt);
    end
    tick();
    nvec++;
    if (burst_cnt !== 8'd4 || outstanding !== 9'd4) begin
      nerr++;
      $display("FAIL credit stall: got cnt=%0d out=%0d, want cnt=4 out=4", burst_cnt, outstanding);
    end
    rd_data_valid = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    #1;
    nvec++;
    if (outstanding !== 9'd3 || dat_cnt !== 8'd1 || cmd_en !== 1'b1) begin
      nerr++;
      $display("FAIL credit return: got out=%0d dc=%0d en=%b, want out=3 dc=1 en=1", outstanding, dat_cnt, cmd_en);
    end
    tick();
    nvec++;
    if (outstanding !== 9'd4 || burst_cnt !== 8'd5 || cmd_en !== 1'b0) begin
      nerr++;
      $display("FAIL credit reissue: got out=%0d cnt=%0d en=%b, want out=4 cnt=5 en=0", outstanding, burst_cnt, cmd_en);
    end
    tick();
    nvec++;
    if (burst_cnt !== 8'd5) begin
      nerr++;
      $display("FAIL credit one_issue: got cnt=%0d, want 5", burst_cnt);
    end
  endtask

  task automatic test_back_to_back();
    preset(8'd7);
    state = READ_DATA0; rdy = 1'b1; rd_data_valid = 1'b0;
    tick();
    rd_data_valid = 1'b1;
    for (int k = 1; k < 8; k++) begin
      #1;
      nvec++;
      if (outstanding !== 9'd1 || burst_cnt !== CW'(k) || dat_cnt !== CW'(k - 1)) begin
        nerr++;
        $display("FAIL b2b cyc%0d: got out=%0d cnt=%0d dc=%0d, want out=1 cnt=%0d dc=%0d",
                 k, outstanding, burst_cnt, dat_cnt, k, k - 1);
      end
      tick();
    end
    #1;
    nvec++;
    if (cmd_done !== 1'b1 || dat_done !== 1'b0 || outstanding !== 9'd1 || dat_cnt !== 8'd7) begin
      nerr++;
      $display("FAIL b2b cmd_done: got cd=%b dd=%b out=%0d dc=%0d, want cd=1 dd=0 out=1 dc=7",
               cmd_done, dat_done, outstanding, dat_cnt);
    end
    tick();
    rd_data_valid = 1'b0;
    nvec++;
    if (dat_done !== 1'b1 || outstanding !== 9'd0 || dat_cnt !== 8'd7) begin
      nerr++;
      $display("FAIL b2b dat_done: got dd=%b out=%0d dc=%0d, want dd=1 out=0 dc=7", dat_done, outstanding, dat_cnt);
    end
  endtask

  task automatic test_single_beat();
    preset(8'd0);
    state = READ_DATA0; rdy = 1'b1;
    tick();
    rdy = 1'b0;
    #1;
    nvec++;
    if (cmd_done !== 1'b1 || burst_cnt !== 8'd0 || outstanding !== 9'd1 || cmd_en !== 1'b0) begin
      nerr++;
      $display("FAIL single issue: got cd=%b cnt=%0d out=%0d en=%b, want cd=1 cnt=0 out=1 en=0",
               cmd_done, burst_cnt, outstanding, cmd_en);
    end
    rd_data_valid = 1'b1;
    tick();
    nvec++;
    if (dat_done !== 1'b1 || dat_cnt !== 8'd0 || outstanding !== 9'd0) begin
      nerr++;
      $display("FAIL single return: got dd=%b dc=%0d out=%0d, want dd=1 dc=0 out=0", dat_done, dat_cnt, outstanding);
    end
    tick();
    rd_data_valid = 1'b0;
    nvec++;
    if (dat_done !== 1'b1 || dat_cnt !== 8'd0 || outstanding !== 9'd0) begin
      nerr++;
      $display("FAIL single extra: got dd=%b dc=%0d out=%0d, want dd=1 dc=0 out=0", dat_done, dat_cnt, outstanding);
    end
  endtask

  task automatic test_mid_reset();
    preset(8'd9);
    state = WRITE_DATA1; wdf_rdy = 1'b1; rdy = 1'b1;
    repeat (5) tick();
    nvec++;
    if (burst_cnt !== 8'd5) begin
      nerr++;
      $display("FAIL midrst pre: got cnt=%0d, want 5", burst_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({cmd_en, burst_cnt, dat_cnt, outstanding, cmd_last, cmd_done, dat_done} !== '0) begin
      nerr++;
      $display("FAIL midrst async: got en=%b bc=%0d dc=%0d out=%0d cd=%b dd=%b, want all 0",
               cmd_en, burst_cnt, dat_cnt, outstanding, cmd_done, dat_done);
    end
    #1 rst_n = 1'b1;
    tick();
    tick();
    nvec++;
    if (burst_cnt !== 8'd0 || cmd_en !== 1'b0 || cmd_done !== 1'b0) begin
      nerr++;
      $display("FAIL midrst rearm: got cnt=%0d en=%b cd=%b, want cnt=0 en=0 cd=0", burst_cnt, cmd_en, cmd_done);
    end
  endtask

  task automatic test_mid_idle();
    preset(8'd9);
    state = WRITE_DATA1; wdf_rdy = 1'b1; rdy = 1'b1;
    repeat (5) tick();
    nvec++;
    if (burst_cnt !== 8'd5) begin
      nerr++;
      $display("FAIL mididle pre: got cnt=%0d, want 5", burst_cnt);
    end
    state = IDLE;
    tick();
    nvec++;
    if ({cmd_en, burst_cnt, dat_cnt, outstanding, cmd_last, cmd_done, dat_done} !== '0) begin
      nerr++;
      $display("FAIL mididle clear: got en=%b bc=%0d dc=%0d out=%0d cd=%b dd=%b, want all 0",
               cmd_en, burst_cnt, dat_cnt, outstanding, cmd_done, dat_done);
    end
  endtask

  task automatic test_len_change();
    preset(8'd2);
    state = WRITE_DATA1; wdf_rdy = 1'b1; rdy = 1'b1;
    tick();
    burst_len = 8'd200;
    repeat (4) tick();
    nvec++;
    if (burst_cnt !== 8'd2 || cmd_done !== 1'b1) begin
      nerr++;
      $display("FAIL lenchg: got cnt=%0d cd=%b, want cnt=2 cd=1", burst_cnt, cmd_done);
    end
    state = IDLE; wdf_rdy = 1'b0; rdy = 1'b0;
    tick();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_write_len3();
    test_write_toggle();
    test_read_credit();
    test_back_to_back();
    test_single_beat();
    test_mid_reset();
    test_mid_idle();
    test_len_change();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
